// File: rtl/imm_seq_pkg.sv
// Shared types and field positions for the multi-chunk immediate sequencer.
package imm_seq_pkg;

  localparam int CHUNK_W = 6;

  // MSB positions of each chunk inside the assembled constant
  localparam int W_HI  = 15;
  localparam int W_MID = 9;
  localparam int W_LO  = 3;
  localparam int N_HI  = 7;
  localparam int N_LO  = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C0   = 3'd1,
    C1   = 3'd2,
    C2   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/imm_seq_timer.sv
// Inter-chunk wait counter: cleared on demand, counts waiting cycles, flags the last allowed one.
module imm_seq_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign term = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/imm_sequencer.sv
// Gathers 6-bit imm chunks into an 8-bit (narrow) or 16-bit (wide) constant.
// Optional IMM_SEQ_SHORT_EN adds short_i: one-chunk sequences with zero-filled low bits.
module imm_sequencer
  import imm_seq_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               wide_i,
`ifdef IMM_SEQ_SHORT_EN
  input  logic               short_i,
`endif
  input  logic               chunk_valid_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  output logic               chunk_ready_o,
  output logic               imm_valid_o,
  output logic [15:0]        imm_o,
  output logic               imm_wide_o,
  input  logic               imm_ready_i,
  output logic               busy_o,
  output logic               timeout_o
);

  state_t      state, state_n;
  logic [15:0] imm;
  logic        wide_q;
  logic        short_q;
  logic        timeout_q;
  logic        accept;
  logic        abort;
  logic        waiting;
  logic        term;

`ifdef IMM_SEQ_SHORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      short_q <= 1'b0;
    end else if (state == IDLE && start_i) begin
      short_q <= short_i;
    end
  end
`else
  assign short_q = 1'b0;
`endif

  // Timer only runs while a chunk is awaited and none arrives; anything else clears it.
  imm_seq_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (!waiting),
    .en  (waiting),
    .term(term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    chunk_ready_o = 1'b0;
    accept        = 1'b0;
    abort         = 1'b0;
    waiting       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_n = C0;
      end
      C0, C1, C2: begin
        chunk_ready_o = 1'b1;
        accept        = chunk_valid_i;
        waiting       = !chunk_valid_i;
        if (accept) begin
          if (state == C0)      state_n = short_q ? DONE : C1;
          else if (state == C1) state_n = wide_q ? C2 : DONE;
          else                  state_n = DONE;
        end else if (term) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      DONE: begin
        if (imm_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Assembly register: each accepted chunk lands in its fixed slot; abort discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      imm       <= '0;
      wide_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (abort) begin
        imm <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              imm    <= '0;
              wide_q <= wide_i;
            end
          end
          C0: begin
            if (accept) begin
              if (wide_q) imm[W_HI -: CHUNK_W] <= chunk_i;
              else        imm[N_HI -: CHUNK_W] <= chunk_i;
            end
          end
          C1: begin
            if (accept) begin
              if (wide_q) imm[W_MID -: CHUNK_W] <= chunk_i;
              else        imm[N_LO:0]           <= chunk_i[CHUNK_W-1 -: 2];
            end
          end
          C2: begin
            if (accept) imm[W_LO:0] <= chunk_i[CHUNK_W-1 -: 4];
          end
          default: ;
        endcase
      end
    end
  end

  assign imm_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign imm_o       = imm;
  assign imm_wide_o  = wide_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_imm_sequencer.sv
// Directed and randomized checks of imm_sequencer against an arithmetic reference model.
module tb_imm_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        wide_i;
`ifdef IMM_SEQ_SHORT_EN
  logic        short_i;
`endif
  logic        chunk_valid_i;
  logic [5:0]  chunk_i;
  logic        chunk_ready_o;
  logic        imm_valid_o;
  logic [15:0] imm_o;
  logic        imm_wide_o;
  logic        imm_ready_i;
  logic        busy_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  imm_sequencer #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .wide_i       (wide_i),
`ifdef IMM_SEQ_SHORT_EN
    .short_i      (short_i),
`endif
    .chunk_valid_i(chunk_valid_i),
    .chunk_i      (chunk_i),
    .chunk_ready_o(chunk_ready_o),
    .imm_valid_o  (imm_valid_o),
    .imm_o        (imm_o),
    .imm_wide_o   (imm_wide_o),
    .imm_ready_i  (imm_ready_i),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  // Constant as the sum of weighted chunk values.
  function automatic logic [15:0] ref_imm(input bit w, input bit s,
                                          input logic [5:0] c0, input logic [5:0] c1,
                                          input logic [5:0] c2);
    int v;
    if (w) v = s ? int'(c0) * 1024 : int'(c0) * 1024 + int'(c1) * 16 + int'(c2) / 4;
    else   v = s ? int'(c0) * 4    : int'(c0) * 4 + int'(c1) / 16;
    return 16'(v);
  endfunction

  task automatic set_short(input bit s);
`ifdef IMM_SEQ_SHORT_EN
    short_i = s;
`endif
  endtask

  task automatic idle_inputs();
    start_i       = 1'b0;
    wide_i        = 1'b0;
    set_short(1'b0);
    chunk_valid_i = 1'b0;
    chunk_i       = 6'd0;
    imm_ready_i   = 1'b0;
  endtask

  task automatic run_seq(input string tag, input bit w, input bit s,
                         input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] c2,
                         input int gap, input int hold);
    logic [15:0] exp;
    int          n;
    exp = ref_imm(w, s, c0, c1, c2);
    n   = s ? 1 : (w ? 3 : 2);
    start_i = 1'b1;
    wide_i  = w;
    set_short(s);
    tick();
    start_i = 1'b0;
    wide_i  = 1'($urandom);
    set_short(1'($urandom));
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        chunk_valid_i = 1'b0;
        chunk_i       = 6'($urandom);
        imm_ready_i   = 1'($urandom);
        chk1({tag, ":rdy_gap"}, chunk_ready_o, 1'b1);
        tick();
      end
      chunk_valid_i = 1'b1;
      chunk_i       = (k == 0) ? c0 : ((k == 1) ? c1 : c2);
      imm_ready_i   = 1'($urandom);
      chk1({tag, ":rdy"}, chunk_ready_o, 1'b1);
      chk1({tag, ":vld_early"}, imm_valid_o, 1'b0);
      tick();
    end
    chunk_valid_i = 1'b0;
    imm_ready_i   = 1'b0;
    chk1({tag, ":vld"}, imm_valid_o, 1'b1);
    chk16({tag, ":imm"}, imm_o, exp);
    chk1({tag, ":wide"}, imm_wide_o, w);
    for (int h = 0; h < hold; h++) begin
      start_i       = 1'b1;
      chunk_valid_i = 1'b1;
      chunk_i       = 6'($urandom);
      tick();
      chk1({tag, ":hold_vld"}, imm_valid_o, 1'b1);
      chk16({tag, ":hold_imm"}, imm_o, exp);
      chk1({tag, ":hold_to"}, timeout_o, 1'b0);
      chk1({tag, ":hold_rdy"}, chunk_ready_o, 1'b0);
    end
    chunk_valid_i = 1'b0;
    start_i       = 1'b1;
    imm_ready_i   = 1'b1;
    tick();
    start_i     = 1'b0;
    imm_ready_i = 1'b0;
    chk1({tag, ":rel_busy"}, busy_o, 1'b0);
    chk1({tag, ":rel_vld"}, imm_valid_o, 1'b0);
    tick();
    chk1({tag, ":stay_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    logic [5:0] a, b, c;
    bit         w, s;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_vld", imm_valid_o, 1'b0);
    chk1("rst_rdy", chunk_ready_o, 1'b0);
    chk1("rst_to", timeout_o, 1'b0);
    chk1("rst_wide", imm_wide_o, 1'b0);
    chk16("rst_imm", imm_o, 16'h0000);
    rst = 1'b0;

    chunk_valid_i = 1'b1;
    tick();
    chk1("idle_rdy", chunk_ready_o, 1'b0);
    chk1("idle_busy", busy_o, 1'b0);
    chunk_valid_i = 1'b0;

    run_seq("narrow", 1'b0, 1'b0, 6'h2A, 6'h30, 6'h00, 0, 0);
    run_seq("wide", 1'b1, 1'b0, 6'h3F, 6'h15, 6'h2C, 0, 0);
    run_seq("bp", 1'b1, 1'b0, 6'h3F, 6'h15, 6'h2C, 0, 5);
    run_seq("bp_long", 1'b0, 1'b0, 6'h11, 6'h3F, 6'h00, 0, TIMEOUT + 2);

    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom);
`ifdef IMM_SEQ_SHORT_EN
      s = ($urandom_range(0, 3) == 0);
`else
      s = 1'b0;
`endif
      a = 6'($urandom);
      b = 6'($urandom);
      c = 6'($urandom);
      run_seq("rand", w, s, a, b, c, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Timeout abort after one chunk of a wide sequence.
    start_i = 1'b1;
    wide_i  = 1'b1;
    tick();
    start_i       = 1'b0;
    chunk_valid_i = 1'b1;
    chunk_i       = 6'h3F;
    tick();
    chunk_valid_i = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk1("to_wait_busy", busy_o, 1'b1);
      chk1("to_wait_pulse", timeout_o, 1'b0);
      tick();
    end
    chk1("to_busy", busy_o, 1'b0);
    chk1("to_pulse", timeout_o, 1'b1);
    chk16("to_imm", imm_o, 16'h0000);
    chk1("to_vld", imm_valid_o, 1'b0);
    tick();
    chk1("to_pulse_end", timeout_o, 1'b0);

    // Accept on the terminal cycle wins over the abort.
    start_i = 1'b1;
    wide_i  = 1'b1;
    tick();
    start_i       = 1'b0;
    chunk_valid_i = 1'b1;
    chunk_i       = 6'h05;
    tick();
    chunk_valid_i = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chunk_valid_i = 1'b1;
    chunk_i       = 6'h2B;
    tick();
    chk1("term_busy", busy_o, 1'b1);
    chk1("term_pulse", timeout_o, 1'b0);
    chunk_i = 6'h3C;
    tick();
    chunk_valid_i = 1'b0;
    chk1("term_vld", imm_valid_o, 1'b1);
    chk16("term_imm", imm_o, ref_imm(1'b1, 1'b0, 6'h05, 6'h2B, 6'h3C));
    imm_ready_i = 1'b1;
    tick();
    imm_ready_i = 1'b0;
    chk1("term_rel", busy_o, 1'b0);

    // Reset in C1 with a chunk on offer.
    start_i = 1'b1;
    wide_i  = 1'b1;
    tick();
    start_i       = 1'b0;
    chunk_valid_i = 1'b1;
    chunk_i       = 6'h2A;
    tick();
    chunk_i = 6'h15;
    rst     = 1'b1;
    tick();
    rst           = 1'b0;
    chunk_valid_i = 1'b0;
    chk1("mrst_busy", busy_o, 1'b0);
    chk1("mrst_rdy", chunk_ready_o, 1'b0);
    chk1("mrst_vld", imm_valid_o, 1'b0);
    chk1("mrst_wide", imm_wide_o, 1'b0);
    chk1("mrst_to", timeout_o, 1'b0);
    chk16("mrst_imm", imm_o, 16'h0000);
    run_seq("post_rst", 1'b0, 1'b0, 6'h01, 6'h20, 6'h00, 0, 0);

`ifdef IMM_SEQ_SHORT_EN
    run_seq("short_wide", 1'b1, 1'b1, 6'h21, 6'h3F, 6'h3F, 0, 0);
    run_seq("short_narrow", 1'b0, 1'b1, 6'h3F, 6'h3F, 6'h3F, 1, 1);
    run_seq("full_after_short", 1'b1, 1'b0, 6'h21, 6'h01, 6'h3F, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
